mem_arbiter: RTL and testbench

Round-robin arbiter that shares the 32x8 request/acknowledge memory between `NUM_REQ` requesters. It accepts one request at a time, drives the memory's `read`/`write`/`addr`/`data_i` strobes stable until `ack`, and returns read data or a write completion to the granted requester. It sits between client blocks and the memory, so the memory's hold-until-ack rule is met in one place.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arbiter_rr.sv | 34 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state type and default abort timeout for mem_arbiter.
package mem_arb_pkg;
  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: search starts one past the last-granted
// requester and wraps, so every requester is reached within NUM_REQ grants.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  // first requesting index after last_i, modulo NUM_REQ
  always_comb begin : search
    logic             found;
    logic [PTR_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for the 32x8 request/ack memory: one transaction at a
// time, strobes held until ack. Optional ISSUE abort: MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_write_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]              rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic                           mem_read_o,
  output logic                           mem_write_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  input  logic                           mem_ack_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   gidx_s;
  logic               arb_en_s;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [4:0]         cnt_q;
  logic               rsp_err_q;
`else
  logic               unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 0);
`endif

  // grants are only offered from IDLE and never while reset is applied
  assign arb_en_s = (state_q == IDLE) & rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i  (req_valid_i),
    .last_i (ptr_q),
    .en_i   (arb_en_s),
    .gnt_o  (grant_s),
    .idx_o  (gidx_s)
  );

  // transaction FSM; ptr_q doubles as the index of the requester being served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_q       <= 5'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
          cnt_q       <= 5'd0;
`endif
          if (|grant_s) begin
            ptr_q       <= gidx_s;
            addr_q      <= req_addr_i[gidx_s];
            wdata_q     <= req_wdata_i[gidx_s];
            mem_write_q <= req_write_i[gidx_s];
            mem_read_q  <= ~req_write_i[gidx_s];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack_i) begin
            rsp_rdata_q <= mem_read_q ? mem_rdata_i : '0;
            rsp_valid_q <= NUM_REQ'(1'b1) << ptr_q;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= RESP;
`ifdef MEM_ARBITER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == 5'(TIMEOUT - 1)) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= NUM_REQ'(1'b1) << ptr_q;
            rsp_err_q   <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_q + 5'd1;
`endif
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = grant_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester queues, a latency-randomizing
// memory, and a transaction-level reference model of grant order and responses.
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  typedef struct { bit w; logic [4:0] a; logic [7:0] d; } req_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N-1:0][4:0] req_addr;
  logic [N-1:0][7:0] req_wdata;
  logic [7:0]        rsp_rdata, mem_addr_w, mem_wdata, mem_rdata;
  logic [4:0]        mem_addr;
  logic              rsp_err, mem_read, mem_write, mem_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  int n_vec = 0, n_bad = 0;
  req_t rq [N][$];
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  // reference model: one outstanding transaction, its owner and age
  bit m_out, m_w, m_ack_prev, m_to_prev;
  int m_ptr, m_owner, m_age, m_issue_n;
  logic [4:0] m_a;
  logic [7:0] m_d;
  // memory model
  bit mm_busy, mem_noack, spur_en;
  int mm_cnt, mm_wait;
  int grant_log[$];
  logic last_err;
  logic [7:0] last_rdata;
  int stb_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic bit busy_any();
    bit b;
    b = m_out;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic push_req(input int i, input bit w, input int a, input int d);
    req_t r;
    r.w = w; r.a = 5'(a); r.d = 8'(d);
    rq[i].push_back(r);
  endtask

  task automatic step();
    bit issuing, exp_rsp;
    int pick;
    logic [N-1:0] exp_v;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = 8'($urandom);
    if (mm_busy && !(mem_read || mem_write)) mm_busy = 1'b0;
    if (mm_busy) begin
      mm_cnt++;
      if (!mem_noack && mm_cnt == mm_wait) begin
        mem_ack = 1'b1;
        if (mem_read) mem_rdata = mem[mem_addr];
        if (mem_write) mem[mem_addr] = mem_wdata;
        mm_busy = 1'b0;
      end
    end else if (mem_read || mem_write) begin
      mm_busy = 1'b1; mm_cnt = 0; mm_wait = $urandom_range(3, 12);
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1; req_write[i] = rq[i][0].w;
        req_addr[i] = rq[i][0].a; req_wdata[i] = rq[i][0].d;
      end else begin
        req_valid[i] = 1'b0; req_write[i] = 1'($urandom);
        req_addr[i] = 5'($urandom); req_wdata[i] = 8'($urandom);
      end
    end
    #1;
    if (m_out) m_age++;
    exp_rsp = m_out && (m_ack_prev || m_to_prev);
    issuing = m_out && m_age >= 1 && !exp_rsp;
    exp_v = exp_rsp ? oh(m_owner) : '0;
    chk_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_rsp) begin
      chk_eq("rsp_rdata", 32'(rsp_rdata), (m_w || m_to_prev) ? 32'd0 : 32'(ref_mem[m_a]));
      chk_eq("rsp_err", 32'(rsp_err), 32'(m_to_prev));
      if (m_w && !m_to_prev) ref_mem[m_a] = m_d;
      m_out = 1'b0;
    end
    if (|rsp_valid) begin last_err = rsp_err; last_rdata = rsp_rdata; end
    chk_eq("mem_read", 32'(mem_read), 32'(issuing && !m_w));
    chk_eq("mem_write", 32'(mem_write), 32'(issuing && m_w));
    chk_eq("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    if (issuing) begin
      chk_eq("mem_addr", 32'(mem_addr), 32'(m_a));
      chk_eq("mem_wdata", 32'(mem_wdata), 32'(m_d));
    end
    if (mem_read || mem_write) stb_cnt++;
    pick = rr_pick(req_valid, m_ptr);
    exp_v = (!m_out && !exp_rsp && pick >= 0) ? oh(pick) : '0;
    chk_eq("req_ready", 32'(req_ready), 32'(exp_v));
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin
        grant_log.push_back(i);
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    if (|exp_v) begin
      m_out = 1'b1; m_owner = pick; m_ptr = pick; m_age = 0; m_issue_n = 0;
      m_w = req_write[pick]; m_a = req_addr[pick]; m_d = req_wdata[pick];
    end
    m_ack_prev = issuing && mem_ack;
    if (issuing) m_issue_n++;
    m_to_prev = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    m_to_prev = issuing && !mem_ack && (m_issue_n == TO);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    req_valid = '0; mem_ack = 1'b0; mm_busy = 1'b0;
    m_out = 1'b0; m_ack_prev = 1'b0; m_to_prev = 1'b0; m_ptr = N - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (busy_any() && n < budget) begin step(); n++; end
    chk_eq("drain_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    rst_n = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_noack = 1'b0; spur_en = 1'b0;
    last_err = 1'b0; last_rdata = '0; stb_cnt = 0; m_issue_n = 0; m_age = 0;
    #2 do_reset();

    // write and read of addr 31 requested together: req0 first after reset
    push_req(0, 1'b1, 31, 8'h3C);
    push_req(1, 1'b0, 31, 8'h00);
    grant_log.delete();
    run_idle(60);
    chk_eq("ilv_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk_eq("ilv_first", 32'(grant_log[0]), 32'd0);
      chk_eq("ilv_second", 32'(grant_log[1]), 32'd1);
    end
    chk_eq("ilv_rdata", 32'(last_rdata), 32'h3C);

    // both requesters held for four transactions
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      push_req(0, 1'($urandom), $urandom_range(0, 31), $urandom);
      push_req(1, 1'($urandom), $urandom_range(0, 31), $urandom);
    end
    run_idle(120);
    chk_eq("rr_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4)
      for (int k = 0; k < 4; k++) chk_eq("rr_order", 32'(grant_log[k]), 32'(k % 2));

    // single write then read of addr 5
    push_req(0, 1'b1, 5, 8'hA5);
    push_req(0, 1'b0, 5, 8'h00);
    run_idle(60);
    chk_eq("wr_rd_data", 32'(last_rdata), 32'hA5);
    chk_eq("wr_rd_err", 32'(last_err), 32'd0);

    // reset three cycles after the strobe rises
    mem_noack = 1'b1;
    push_req(0, 1'b0, 7, 8'h00);
    n = 0;
    while (!mem_read && n < 10) begin step(); n++; end
    chk_eq("mid_strobe_rise", 32'(mem_read), 32'd1);
    repeat (3) step();
    do_reset();
    mem_noack = 1'b0;
    grant_log.delete();
    push_req(1, 1'b0, 7, 8'h00);
    run_idle(60);
    chk_eq("post_rst_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) chk_eq("post_rst_req1", 32'(grant_log[0]), 32'd1);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // memory never acks: abort after TIMEOUT strobe cycles
    mem_noack = 1'b1;
    stb_cnt = 0;
    push_req(0, 1'b1, 3, 8'h55);
    run_idle(60);
    chk_eq("to_strobe_cycles", 32'(stb_cnt), 32'(TO));
    chk_eq("to_err", 32'(last_err), 32'd1);
    chk_eq("to_rdata", 32'(last_rdata), 32'd0);
    mem_noack = 1'b0;
`endif

    // random traffic with spurious acks while the memory is idle
    spur_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() == 0 && $urandom_range(0, 2) == 0)
          push_req(i, 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 3), $urandom);
      step();
    end
    spur_en = 1'b0;
    run_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

endmodule
